// File: rtl/axil_wb_bridge.sv
// rtl/axil_wb_bridge.sv - AXI4-Lite slave to Wishbone master bridge, one transaction at a time
// Optional Wishbone ack timeout: define AXIL_WB_TIMEOUT_EN
module axil_wb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    // AXI4-Lite write address
    input  logic                      s_awvalid_i,
    output logic                      s_awready_o,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr_i,
    input  logic [2:0]                s_awprot_i,
    // AXI4-Lite write data
    input  logic                      s_wvalid_i,
    output logic                      s_wready_o,
    input  logic [DATA_WIDTH-1:0]     s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb_i,
    // AXI4-Lite write response
    output logic                      s_bvalid_o,
    input  logic                      s_bready_i,
    output logic [1:0]                s_bresp_o,
    // AXI4-Lite read
    input  logic                      s_arvalid_i,
    output logic                      s_arready_o,
    input  logic [ADDR_WIDTH-1:0]     s_araddr_i,
    input  logic [2:0]                s_arprot_i,
    output logic                      s_rvalid_o,
    input  logic                      s_rready_i,
    output logic [DATA_WIDTH-1:0]     s_rdata_o,
    output logic [1:0]                s_rresp_o,
    // Wishbone master
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [ADDR_WIDTH-1:0]     wb_addr_o,
    output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    input  logic                      wb_ack_i
);

    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WB_READ  = 3'd1,
        WB_WRITE = 3'd2,
        R_RESP   = 3'd3,
        B_RESP   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    aw_cap_q, aw_cap_d;
    logic                    w_cap_q, w_cap_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [STRB_W-1:0]       sel_q, sel_d;
    logic [1:0]              resp_q, resp_d;

    logic                    ar_hs, aw_hs, w_hs;
    logic                    in_wb;

    // protection attributes carry no meaning on the Wishbone side
    logic                    unused_inputs;

`ifdef AXIL_WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    assign unused_inputs = ^{s_awprot_i, s_arprot_i};
`else
    assign unused_inputs = ^{s_awprot_i, s_arprot_i, TIMEOUT_CYCLES[0]};
`endif

    assign in_wb = (state_q == WB_READ) || (state_q == WB_WRITE);

    // Ready generation: reads only start with no write half pending, and a
    // read handshake in the same cycle blocks both write halves.
    always_comb begin
        s_arready_o = 1'b0;
        s_awready_o = 1'b0;
        s_wready_o  = 1'b0;
        if (!rst && state_q == IDLE) begin
            s_arready_o = !aw_cap_q && !w_cap_q;
            s_awready_o = !aw_cap_q && !(s_arready_o && s_arvalid_i);
            s_wready_o  = !w_cap_q  && !(s_arready_o && s_arvalid_i);
        end
        ar_hs = s_arready_o && s_arvalid_i;
        aw_hs = s_awready_o && s_awvalid_i;
        w_hs  = s_wready_o  && s_wvalid_i;
    end

    // Next-state and datapath update for the transaction FSM
    always_comb begin
        state_d  = state_q;
        aw_cap_d = aw_cap_q;
        w_cap_d  = w_cap_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        sel_d    = sel_q;
        resp_d   = resp_q;
`ifdef AXIL_WB_TIMEOUT_EN
        cnt_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    addr_d  = s_araddr_i;
                    sel_d   = '1;
                    state_d = WB_READ;
                end else begin
                    if (aw_hs) begin
                        aw_cap_d = 1'b1;
                        addr_d   = s_awaddr_i;
                    end
                    if (w_hs) begin
                        w_cap_d = 1'b1;
                        wdata_d = s_wdata_i;
                        sel_d   = s_wstrb_i;
                    end
                    if (aw_cap_d && w_cap_d) begin
                        state_d = WB_WRITE;
                    end
                end
            end
            WB_READ, WB_WRITE: begin
                if (wb_ack_i) begin
                    resp_d = 2'b00;
                    if (state_q == WB_READ) begin
                        rdata_d = wb_data_i;
                        state_d = R_RESP;
                    end else begin
                        state_d = B_RESP;
                    end
`ifdef AXIL_WB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_d = 2'b10;
                    if (state_q == WB_READ) begin
                        rdata_d = '0;
                        state_d = R_RESP;
                    end else begin
                        state_d = B_RESP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            R_RESP: begin
                if (s_rready_i) begin
                    state_d = IDLE;
                end
            end
            B_RESP: begin
                if (s_bready_i) begin
                    state_d  = IDLE;
                    aw_cap_d = 1'b0;
                    w_cap_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously to abort any transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            aw_cap_q <= 1'b0;
            w_cap_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            sel_q    <= '0;
            resp_q   <= 2'b00;
`ifdef AXIL_WB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            aw_cap_q <= aw_cap_d;
            w_cap_q  <= w_cap_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            sel_q    <= sel_d;
            resp_q   <= resp_d;
`ifdef AXIL_WB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign wb_cyc_o   = in_wb;
    assign wb_stb_o   = in_wb;
    assign wb_we_o    = (state_q == WB_WRITE);
    assign wb_addr_o  = addr_q;
    assign wb_sel_o   = sel_q;
    assign wb_data_o  = wdata_q;
    assign s_rvalid_o = (state_q == R_RESP);
    assign s_bvalid_o = (state_q == B_RESP);
    assign s_rdata_o  = rdata_q;
    assign s_rresp_o  = resp_q;
    assign s_bresp_o  = resp_q;

endmodule

// File: doc/axil_wb_bridge.md
AXIL_WB_BRIDGE -- requirements
Module: axil_wb_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI and Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (bytes = DATA_WIDTH/8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, Wishbone wait limit (used only under REQ-030).
REQ-004 SHALL use one clock and an asynchronous active-high reset: clk  in  1  clock; rst  in  1  reset.
REQ-005 SHALL have AXI4-Lite write address ports: s_awvalid_i in 1; s_awready_o out 1; s_awaddr_i in ADDR_WIDTH; s_awprot_i in 3 (ignored).
REQ-006 SHALL have AXI4-Lite write data ports: s_wvalid_i in 1; s_wready_o out 1; s_wdata_i in DATA_WIDTH; s_wstrb_i in DATA_WIDTH/8.
REQ-007 SHALL have AXI4-Lite write response ports: s_bvalid_o out 1; s_bready_i in 1; s_bresp_o out 2.
REQ-008 SHALL have AXI4-Lite read ports: s_arvalid_i in 1; s_arready_o out 1; s_araddr_i in ADDR_WIDTH; s_arprot_i in 3 (ignored); s_rvalid_o out 1; s_rready_i in 1; s_rdata_o out DATA_WIDTH; s_rresp_o out 2.
REQ-009 SHALL have Wishbone master ports: wb_cyc_o out 1; wb_stb_o out 1; wb_we_o out 1; wb_addr_o out ADDR_WIDTH; wb_sel_o out DATA_WIDTH/8; wb_data_o out DATA_WIDTH; wb_data_i in DATA_WIDTH; wb_ack_i in 1.

Function
REQ-010 SHALL implement FSM states IDLE, WB_READ, WB_WRITE, R_RESP, B_RESP; one transaction outstanding at a time.
REQ-011 In IDLE, s_arready_o SHALL be 1 only while no write half is captured; read address is latched on the AR handshake edge and the FSM moves to WB_READ.
REQ-012 In IDLE, s_awready_o SHALL be 1 while no AW is captured, s_wready_o SHALL be 1 while no W is captured; AW and W accepted independently, any order, same cycle allowed.
REQ-013 Once either write half is captured, the write SHALL be committed: s_arready_o held 0 until B handshake completes.
REQ-014 Simultaneous AR and AW/W valid in IDLE with nothing captured: read SHALL win; write halves not accepted that cycle.
REQ-015 When both write halves are captured, FSM SHALL enter WB_WRITE next edge.
REQ-016 In WB_READ/WB_WRITE, wb_cyc_o and wb_stb_o SHALL be 1; wb_we_o = 1 only in WB_WRITE; wb_addr_o, wb_data_o, wb_sel_o (= captured wstrb; all-ones on reads) held stable.
REQ-017 On wb_ack_i = 1: cyc/stb SHALL drop at that edge; read data latched into s_rdata_o; next state R_RESP (read) or B_RESP (write).
REQ-018 Latency: AR handshake at cycle N -> wb_stb_o first high cycle N+1 -> ack at cycle M -> s_rvalid_o high at M+1.
REQ-019 s_rvalid_o / s_bvalid_o SHALL stay 1 with stable data/resp until s_rready_i / s_bready_i; handshake edge returns FSM to IDLE and clears captures.
REQ-020 s_rresp_o and s_bresp_o SHALL be 2'b00 (OKAY) except per REQ-030.
REQ-021 wb_ack_i outside WB_READ/WB_WRITE SHALL be ignored.

Reset
REQ-022 While rst = 1, all outputs SHALL be 0 (ready, valid, cyc, stb, we, addr, sel, data, resp, rdata), FSM = IDLE, captures cleared, asynchronously.
REQ-023 Reset asserted mid-transaction SHALL abort it immediately; no response is issued after release.
REQ-024 First handshake SHALL be possible on the first clk edge after rst deasserts.

Configuration
REQ-030 With AXIL_WB_TIMEOUT_EN defined: a counter SHALL start at 0 on entering WB_READ/WB_WRITE, increment each cycle without ack; on reaching TIMEOUT_CYCLES, cyc/stb drop and the response issues with resp = 2'b10 (SLVERR), s_rdata_o = 0.
REQ-031 Without AXIL_WB_TIMEOUT_EN: no counter logic; bridge SHALL wait indefinitely for wb_ack_i; resp always 2'b00.

Verification
REQ-040 Read: AR addr 0x0000_0010, ack after 3 cycles with wb_data_i 0xCAFE_BABE -> wb_we_o 0, wb_sel_o 0xF, s_rdata_o 0xCAFE_BABE, s_rresp_o 00, rvalid held through 2 cycles of rready = 0.
REQ-041 Write, W before AW by 2 cycles: wdata 0x1234_5678, wstrb 0x3, awaddr 0x0000_0100 -> single WB cycle with we 1, sel 0x3, data 0x1234_5678; bvalid after ack, bresp 00.
REQ-042 AR and AW+W valid same cycle -> read fully completes first, then write executes; exactly two WB cycles.
REQ-043 rst pulsed while in WB_READ -> cyc/stb 0 immediately; no rvalid after release; next read completes normally.
REQ-044 With AXIL_WB_TIMEOUT_EN, TIMEOUT_CYCLES 8, no ack -> stb drops after 8 cycles, s_rresp_o 2'b10, s_rdata_o 0; without macro, stb stays high for 1000 cycles.
